mmio_gpio: RTL and testbench

- Parametrised memory-mapped GPIO peripheral on the CPU load/store port.
- Replaces the hard-wired switch register and LEDR register at the SoC top.
- Provides NCH channels, each with one input port and one output port.
- Per input channel: 2-FF synchronisation, sticky rising-edge capture and a masked interrupt.
- The top uses o_hit to choose between o_rddata and memory read data, and to gate memory writes.

---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_in_sync.sv | 30 +++
 rtl/mmio_gpio.sv | 122 ++++++++++++
 tb/tb_mmio_gpio.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the memory-mapped GPIO block.
`timescale 1ns/1ps
package gpio_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OFF_OUT    = 4'h0;
  localparam logic [3:0] OFF_IN     = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_MASK   = 4'hC;

  // Register select is the word index within a channel's 16-byte window.
  typedef enum logic [1:0] {
    REG_OUT    = OFF_OUT[3:2],
    REG_IN     = OFF_IN[3:2],
    REG_STATUS = OFF_STATUS[3:2],
    REG_MASK   = OFF_MASK[3:2]
  } gpio_reg_e;

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [3:0] be);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser plus previous-value flop; reports rising edges.
`timescale 1ns/1ps
module gpio_in_sync #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_c_o
);

  logic [W-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync_o   = sync2_q;
  assign rise_c_o = sync2_q & ~prev_q;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: per-channel OUT/IN/STATUS/MASK registers on the CPU load/store port.
`timescale 1ns/1ps
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter logic [3:0]  BASE_HI = 4'hA
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          i_addr,
  input  logic                 i_rd,
  input  logic                 i_wr,
  input  logic [31:0]          i_wrdata,
  input  logic [3:0]           i_byte_en,
  output logic                 o_hit,
  output logic [31:0]          o_rddata,
  output logic                 o_rdvalid,
  input  logic [NCH*IN_W-1:0]  i_gpio_in,
  output logic [NCH*OUT_W-1:0] o_gpio_out,
  output logic                 o_irq
);

  logic [OUT_W-1:0] out_q    [NCH];
  logic [OUT_W-1:0] out_d    [NCH];
  logic [IN_W-1:0]  status_q [NCH];
  logic [IN_W-1:0]  status_d [NCH];
  logic [IN_W-1:0]  mask_q   [NCH];
  logic [IN_W-1:0]  mask_d   [NCH];
  logic [IN_W-1:0]  in_sync  [NCH];
  logic [IN_W-1:0]  in_rise  [NCH];

  logic [DATA_W-1:0] rddata_q, rddata_d, rd_val, lane;
  logic              rdvalid_q, rdvalid_d, irq_q, irq_d;
  logic              wr_hit, rd_hit, acc_ok;
  logic [3:0]        ch;
  gpio_reg_e         sel;
  logic              unused_addr;

  assign ch     = i_addr[7:4];
  assign sel    = gpio_reg_e'(i_addr[3:2]);
  assign acc_ok = (i_addr[11:8] == 4'h0) && ({28'h0, ch} < NCH);
  assign o_hit  = (i_rd | i_wr) && (i_addr[15:12] == BASE_HI);
  assign wr_hit = i_wr && o_hit;
  // A simultaneous read and write performs only the write.
  assign rd_hit = i_rd && !i_wr && o_hit;
  assign lane   = be_to_mask(i_byte_en);
  assign unused_addr = ^{i_addr[31:16], i_addr[1:0]};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gpio_in_sync #(.W(IN_W)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .pin_i    (i_gpio_in[g*IN_W +: IN_W]),
      .sync_o   (in_sync[g]),
      .rise_c_o (in_rise[g])
    );
    assign o_gpio_out[g*OUT_W +: OUT_W] = out_q[g];
  end

  // Register writes, edge capture, read mux and interrupt reduction.
  always_comb begin
    rd_val = '0;
    irq_d  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      out_d[c]    = out_q[c];
      mask_d[c]   = mask_q[c];
      status_d[c] = status_q[c];
      if (wr_hit && acc_ok && ({28'h0, ch} == c)) begin
        case (sel)
          REG_OUT:    out_d[c]    = OUT_W'((DATA_W'(out_q[c]) & ~lane) | (i_wrdata & lane));
          REG_MASK:   mask_d[c]   = IN_W'((DATA_W'(mask_q[c]) & ~lane) | (i_wrdata & lane));
          REG_STATUS: status_d[c] = status_q[c] & ~IN_W'(i_wrdata & lane);
          default:    ;
        endcase
      end
      // A new edge always wins over a clear in the same cycle.
      status_d[c] = status_d[c] | in_rise[c];
      if (acc_ok && ({28'h0, ch} == c)) begin
        case (sel)
          REG_OUT:    rd_val = DATA_W'(out_q[c]);
          REG_IN:     rd_val = DATA_W'(in_sync[c]);
          REG_STATUS: rd_val = DATA_W'(status_q[c]);
          REG_MASK:   rd_val = DATA_W'(mask_q[c]);
          default:    rd_val = '0;
        endcase
      end
      irq_d = irq_d | (|(status_q[c] & mask_q[c]));
    end
    rdvalid_d = rd_hit;
    rddata_d  = rd_hit ? rd_val : rddata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        out_q[c]    <= '0;
        status_q[c] <= '0;
        mask_q[c]   <= '0;
      end
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        out_q[c]    <= out_d[c];
        status_q[c] <= status_d[c];
        mask_q[c]   <= mask_d[c];
      end
      rddata_q  <= rddata_d;
      rdvalid_q <= rdvalid_d;
      irq_q     <= irq_d;
    end
  end

  assign o_rddata  = rddata_q;
  assign o_rdvalid = rdvalid_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with default parameters (2 channels, 8-bit in/out).
`timescale 1ns/1ps
module tb_mmio_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr, i_wrdata, o_rddata;
  logic        i_rd, i_wr, o_hit, o_rdvalid, o_irq;
  logic [3:0]  i_byte_en;
  logic [15:0] i_gpio_in, o_gpio_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmio_gpio dut (
    .clk        (clk),
    .reset      (reset),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .i_wr       (i_wr),
    .i_wrdata   (i_wrdata),
    .i_byte_en  (i_byte_en),
    .o_hit      (o_hit),
    .o_rddata   (o_rddata),
    .o_rdvalid  (o_rdvalid),
    .i_gpio_in  (i_gpio_in),
    .o_gpio_out (o_gpio_out),
    .o_irq      (o_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    i_addr    = a;
    i_wrdata  = d;
    i_byte_en = be;
    i_wr      = 1'b1;
    tick();
    i_wr      = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    i_addr = a;
    i_rd   = 1'b1;
    tick();
    i_rd   = 1'b0;
    chk({tag, "_vld"}, 32'(o_rdvalid), 32'd1);
    chk(tag, o_rddata, exp);
  endtask

  initial begin
    reset = 1'b0; i_addr = '0; i_rd = 1'b0; i_wr = 1'b0;
    i_wrdata = '0; i_byte_en = '0; i_gpio_in = '0;
    tick(); tick();
    chk("rst_out",   32'(o_gpio_out), 32'h0);
    chk("rst_rdv",   32'(o_rdvalid),  32'h0);
    chk("rst_rdata", o_rddata,        32'h0);
    chk("rst_irq",   32'(o_irq),      32'h0);
    reset = 1'b1;
    tick();
    rd("in0_after_rst", 32'hA004, 32'h0);
    tick();
    chk("rdv_drops", 32'(o_rdvalid), 32'h0);

    // Byte lanes and width truncation.
    wr(32'hA000, 32'h0000_005A, 4'b0001);
    wr(32'hA010, 32'h0000_01FF, 4'b0010);
    chk("out_lanes", 32'(o_gpio_out), 32'h0000_005A);
    rd("out1_rd", 32'hA010, 32'h0);
    rd("out0_raw", 32'hA000, 32'h5A);
    wr(32'hA000, 32'h0000_00FF, 4'b0000);
    chk("out_no_lane", 32'(o_gpio_out), 32'h0000_005A);
    wr(32'hA013, 32'h1234_56C3, 4'b1111);
    rd("out1_trunc", 32'hA010, 32'hC3);
    chk("out_both", 32'(o_gpio_out), 32'h0000_C35A);

    // Input sync and sticky edge capture.
    i_gpio_in = 16'h0081;
    tick(); tick(); tick(); tick();
    rd("in0_val", 32'hA004, 32'h81);
    rd("st0_set", 32'hA008, 32'h81);
    rd("st1_zero", 32'hA018, 32'h0);
    chk("irq_unmasked", 32'(o_irq), 32'h0);
    i_gpio_in = 16'h0000;
    tick(); tick(); tick(); tick();
    rd("st0_sticky", 32'hA008, 32'h81);

    // Masked interrupt and W1C.
    wr(32'hA00C, 32'h0000_0001, 4'b0001);
    tick(); tick();
    chk("irq_on", 32'(o_irq), 32'h1);
    wr(32'hA008, 32'h0000_0001, 4'b0001);
    tick();
    chk("irq_off", 32'(o_irq), 32'h0);
    rd("st0_w1c", 32'hA008, 32'h80);
    rd("mask0_rd", 32'hA00C, 32'h01);

    // Edge on bit 0 in the same cycle as its W1C: set wins; bit 7 clears.
    i_gpio_in = 16'h0001;
    tick(); tick();
    wr(32'hA008, 32'h0000_0081, 4'b0001);
    rd("st0_setwins", 32'hA008, 32'h01);
    tick();
    chk("irq_setwins", 32'(o_irq), 32'h1);

    // Decode misses inside and outside the block.
    rd("bad_ch", 32'hA040, 32'h0);
    i_addr = 32'hA100;
    i_rd   = 1'b1;
    #1;
    chk("hit_a100", 32'(o_hit), 32'h1);
    tick();
    i_rd = 1'b0;
    chk("bad_off_vld", 32'(o_rdvalid), 32'h1);
    chk("bad_off", o_rddata, 32'h0);
    rd("prime_rd", 32'hA004, 32'h01);
    i_addr = 32'hB000;
    i_rd   = 1'b1;
    #1;
    chk("hit_b000", 32'(o_hit), 32'h0);
    tick();
    i_rd = 1'b0;
    chk("miss_vld", 32'(o_rdvalid), 32'h0);
    chk("miss_hold", o_rddata, 32'h01);

    // Read and write together: write only.
    i_addr = 32'hA00C; i_wrdata = 32'h3; i_byte_en = 4'b0001;
    i_wr = 1'b1; i_rd = 1'b1;
    tick();
    i_wr = 1'b0; i_rd = 1'b0;
    chk("rdwr_vld", 32'(o_rdvalid), 32'h0);
    rd("rdwr_mask", 32'hA00C, 32'h03);

    // Reset during a read drops it; a high pin gives one edge after release.
    i_addr = 32'hA000; i_rd = 1'b1; reset = 1'b0;
    tick();
    i_rd = 1'b0;
    chk("rstrd_vld", 32'(o_rdvalid), 32'h0);
    chk("rstrd_data", o_rddata, 32'h0);
    chk("rstrd_out", 32'(o_gpio_out), 32'h0);
    chk("rstrd_irq", 32'(o_irq), 32'h0);
    reset = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    rd("st0_postrst", 32'hA008, 32'h01);
    chk("irq_postrst", 32'(o_irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
